cache_ctrl: RTL and testbench

// - Direct-mapped, write-back, write-allocate cache controller; sits directly downstream of the CPU request generator.
// - Consumes its Address/wr_rd/cs/DOut bus and returns read data plus a ready flag.
// - Services misses through a byte-wide req/ack main-memory port; cache data lives in an internal array.

---
 rtl/cache_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_cache_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// cache_ctrl -- direct-mapped, write-back, write-allocate cache controller.
//
// Sits between the CPU request generator and a byte-wide main memory.
// The cache has 8 lines of 32 bytes. The address splits into
// tag = addr[15:8], index = addr[7:5] and offset = addr[4:0].
//
// Optional feature: define CACHE_STATS_EN to build saturating hit/miss
// counters. When it is undefined, hit_cnt and miss_cnt are tied to zero.
//
// Ports
//   clk, rst            clock (rising edge); asynchronous active-high reset
//   cs, wr_rd           CPU select (a request is a 0->1 edge); 1 = write
//   addr, cpu_din       CPU byte address and write data
//   cpu_dout, rdy       read data (holds until next read hit); 1 = idle
//   mem_req, mem_wr     memory transfer request (held until ack); 1 = write
//   mem_addr, mem_wdata memory byte address and write data
//   mem_rdata, mem_ack  memory read data and one-cycle completion pulse
//   hit_cnt, miss_cnt   statistics counters
//
// Memory handshake: mem_req rises and stays high until the cycle in which
// mem_ack is seen high. mem_rdata is taken in that same cycle. mem_req then
// drops for exactly one cycle before the next transfer. mem_ack is ignored
// while mem_req is low.
module cache_ctrl #(
  parameter int TAG_W    = 8,
  parameter int INDEX_W  = 3,
  parameter int OFFSET_W = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cs,
  input  logic                            wr_rd,
  input  logic [TAG_W+INDEX_W+OFFSET_W-1:0] addr,
  input  logic [7:0]                      cpu_din,
  output logic [7:0]                      cpu_dout,
  output logic                            rdy,
  output logic                            mem_req,
  output logic                            mem_wr,
  output logic [TAG_W+INDEX_W+OFFSET_W-1:0] mem_addr,
  output logic [7:0]                      mem_wdata,
  input  logic [7:0]                      mem_rdata,
  input  logic                            mem_ack,
  output logic [15:0]                     hit_cnt,
  output logic [15:0]                     miss_cnt
);

  localparam int AW     = TAG_W + INDEX_W + OFFSET_W;
  localparam int LINES  = 1 << INDEX_W;
  localparam int LINE_B = 1 << OFFSET_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_HIT    = 3'd2,
    S_WB     = 3'd3,
    S_FILL   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_cs_d;
  logic [AW-1:0]         r_addr;
  logic                  r_wr;
  logic [7:0]            r_din;
  logic [7:0]            r_cpu_dout;
  logic [LINES-1:0]      r_valid;
  logic [LINES-1:0]      r_dirty;
  logic [TAG_W-1:0]      r_tag [LINES];
  logic [7:0]            r_data [LINES*LINE_B];
  logic [OFFSET_W-1:0]   r_cnt;
  logic                  r_mem_req;

  logic [TAG_W-1:0]      w_tag;
  logic [INDEX_W-1:0]    w_idx;
  logic [OFFSET_W-1:0]   w_off;
  logic                  w_accept;
  logic                  w_hit;
  logic                  w_ack;
  logic                  w_last;

  assign w_tag    = r_addr[AW-1 -: TAG_W];
  assign w_idx    = r_addr[OFFSET_W +: INDEX_W];
  assign w_off    = r_addr[OFFSET_W-1:0];
  assign w_accept = cs & ~r_cs_d & (r_state == S_IDLE);
  assign w_hit    = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_ack    = mem_ack & r_mem_req;
  assign w_last   = (r_cnt == {OFFSET_W{1'b1}});

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_LOOKUP;
      S_LOOKUP: begin
        if (w_hit)                             w_state_nxt = S_HIT;
        else if (r_valid[w_idx] & r_dirty[w_idx]) w_state_nxt = S_WB;
        else                                   w_state_nxt = S_FILL;
      end
      S_HIT:    w_state_nxt = S_IDLE;
      S_WB:     if (w_ack && w_last) w_state_nxt = S_FILL;
      S_FILL:   if (w_ack && w_last) w_state_nxt = S_LOOKUP;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Control and tag-store registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cs_d     <= 1'b0;
      r_addr     <= '0;
      r_wr       <= 1'b0;
      r_din      <= '0;
      r_cpu_dout <= '0;
      r_valid    <= '0;
      r_dirty    <= '0;
      r_cnt      <= '0;
      r_mem_req  <= 1'b0;
      for (int i = 0; i < LINES; i++) r_tag[i] <= '0;
    end else begin
      r_cs_d <= cs;
      if (w_accept) begin
        r_addr <= addr;
        r_wr   <= wr_rd;
        r_din  <= cpu_din;
      end
      case (r_state)
        S_LOOKUP: begin
          // A miss raises the first request on the way into WB or FILL.
          if (!w_hit) begin
            r_mem_req <= 1'b1;
            r_cnt     <= '0;
          end
        end
        S_HIT: begin
          if (r_wr) r_dirty[w_idx] <= 1'b1;
          else      r_cpu_dout     <= r_data[{w_idx, w_off}];
        end
        S_WB, S_FILL: begin
          if (w_ack) begin
            // Drop the request for one cycle; the counter wraps 31->0.
            r_mem_req <= 1'b0;
            r_cnt     <= r_cnt + 1'b1;
            if (r_state == S_FILL && w_last) begin
              r_valid[w_idx] <= 1'b1;
              r_dirty[w_idx] <= 1'b0;
              r_tag[w_idx]   <= w_tag;
            end
          end else if (!r_mem_req) begin
            r_mem_req <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Data array: not reset, only written by fills and write hits.
  always_ff @(posedge clk) begin
    if (r_state == S_FILL && w_ack)
      r_data[{w_idx, r_cnt}] <= mem_rdata;
    else if (r_state == S_HIT && r_wr)
      r_data[{w_idx, w_off}] <= r_din;
  end

  // Memory port: address/data are driven only during a burst.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (r_state == S_WB) begin
      mem_addr  = {r_tag[w_idx], w_idx, r_cnt};
      mem_wdata = r_data[{w_idx, r_cnt}];
    end else if (r_state == S_FILL) begin
      mem_addr  = {w_tag, w_idx, r_cnt};
    end
  end

  assign mem_req  = r_mem_req;
  assign mem_wr   = (r_state == S_WB);
  assign rdy      = (r_state == S_IDLE);
  assign cpu_dout = r_cpu_dout;

`ifdef CACHE_STATS_EN
  // r_first marks the first LOOKUP of a request so that the re-LOOKUP
  // after a fill is not counted a second time.
  logic        r_first;
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_first    <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_accept) begin
      r_first <= 1'b1;
    end else if (r_state == S_LOOKUP) begin
      r_first <= 1'b0;
      if (r_first) begin
        if (w_hit) begin
          if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
        end else begin
          if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
        end
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`else
  assign hit_cnt  = 16'h0000;
  assign miss_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl -- directed bench for cache_ctrl.
// A behavioural memory answers mem_req with a random delay. Expected
// memory transfers and expected CPU read data are queued when each request
// is driven, and they are checked when the DUT produces them.
module tb_cache_ctrl;

`ifdef CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int LIMIT = 1000;

  logic        clk;
  logic        rst;
  logic        cs;
  logic        wr_rd;
  logic [15:0] addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        rdy;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem  [65536];   // backing store
  logic [7:0]  gold [65536];   // what the CPU should see
  logic [24:0] exp_q[$];       // {wr, addr, wdata} expected memory transfers
  logic [7:0]  rd_q[$];        // expected cpu_dout after each request
  logic [7:0]  last_rd;
  logic        stray_ack;

  cache_ctrl dut (
    .clk(clk), .rst(rst), .cs(cs), .wr_rd(wr_rd), .addr(addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .rdy(rdy),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] st(input logic [15:0] v);
    return STATS ? v : 16'h0000;
  endfunction

  function automatic logic [7:0] init_val(input int a);
    logic [15:0] w;
    w = a[15:0];
    return w[7:0] ^ w[15:8] ^ 8'h3C;
  endfunction

  task automatic push_wb(input logic [7:0] tag, input logic [2:0] idx);
    logic [15:0] a;
    for (int o = 0; o < 32; o++) begin
      a = {tag, idx, o[4:0]};
      exp_q.push_back({1'b1, a, gold[a]});
    end
  endtask

  task automatic push_fill(input logic [7:0] tag, input logic [2:0] idx);
    logic [15:0] a;
    for (int o = 0; o < 32; o++) begin
      a = {tag, idx, o[4:0]};
      exp_q.push_back({1'b0, a, 8'h00});
    end
  endtask

  // Memory responder: one ack per request, random delay, one-cycle pulse.
  initial begin
    int          dly;
    logic [24:0] e;
    dly       = 0;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req === 1'b1 && rst === 1'b0) begin
        if (dly > 0) dly--;
        else begin
          if (exp_q.size() == 0) chk("mem_unexpected", 32'(exp_q.size()), 1);
          else begin
            e = exp_q.pop_front();
            chk("mem_xfer", {mem_wr, mem_addr, (mem_wr ? mem_wdata : 8'h00)}, e);
          end
          if (mem_wr) mem[mem_addr] = mem_wdata;
          else        mem_rdata = mem[mem_addr];
          mem_ack = 1'b1;
          dly = $urandom_range(0, 2);
        end
      end else if (stray_ack && mem_req === 1'b0) begin
        mem_rdata = 8'hEE;
        mem_ack   = 1'b1;
        stray_ack = 1'b0;
      end
    end
  end

  // Driver: one CPU request, then wait for rdy and score the result.
  task automatic do_req(input logic wr, input logic [15:0] a, input logic [7:0] d,
                        input logic exp_hit, input int min_lat, input logic poke);
    int   lat;
    logic req_seen;
    logic quiet;
    @(negedge clk);
    cs = 1'b1; wr_rd = wr; addr = a; cpu_din = d;
    if (wr) gold[a] = d;
    else    last_rd = gold[a];
    rd_q.push_back(last_rd);
    @(negedge clk);
    cs  = 1'b0;
    lat = 0;
    chk("rdy_drop", rdy, 0);
    req_seen = mem_req;
    while (rdy !== 1'b1 && lat < LIMIT) begin
      @(negedge clk);
      lat++;
      req_seen |= mem_req;
      if (poke && lat == 10) begin
        // New edge while busy; cs then stays high through completion.
        cs = 1'b1; wr_rd = 1'b1; addr = 16'h6660; cpu_din = 8'h55;
        stray_ack = 1'b1;
        chk("busy_rdy", rdy, 0);
      end
    end
    chk("rdy_timeout", rdy, 1);
    if (exp_hit) begin
      chk("hit_latency", lat, 2);
      chk("hit_no_mem_req", req_seen, 0);
    end else begin
      chk("miss_latency_min", 32'(lat >= min_lat), 1);
    end
    chk("cpu_dout", cpu_dout, rd_q.pop_front());
    chk("mem_xfers_left", exp_q.size(), 0);
    if (poke) begin
      quiet = 1'b1;
      repeat (6) begin
        @(negedge clk);
        if (rdy !== 1'b1 || mem_req !== 1'b0) quiet = 1'b0;
      end
      chk("no_retrigger", quiet, 1);
      cs = 1'b0;
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) begin
      mem[i]  = init_val(i);
      gold[i] = mem[i];
    end
    rst = 1'b1; cs = 1'b0; wr_rd = 1'b0; addr = '0; cpu_din = '0;
    stray_ack = 1'b0; last_rd = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_rdy", rdy, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_dout", cpu_dout, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    rst = 1'b0;

    // Cold read miss: fill only.
    push_fill(8'h11, 3'd0);
    do_req(1'b0, 16'h1100, 8'h00, 1'b0, 66, 1'b0);
    chk("miss_cnt_1", miss_cnt, st(16'd1));
    chk("hit_cnt_0", hit_cnt, st(16'd0));

    // Write hit (cpu_dout must keep the previous read), then read it back.
    do_req(1'b1, 16'h1101, 8'hAA, 1'b1, 2, 1'b0);
    chk("hit_cnt_1", hit_cnt, st(16'd1));
    do_req(1'b0, 16'h1101, 8'h00, 1'b1, 2, 1'b0);

    // Another line, then a conflict miss on dirty line 0: WB then FILL.
    push_fill(8'h00, 3'd1);
    do_req(1'b0, 16'h0020, 8'h00, 1'b0, 66, 1'b0);
    push_wb(8'h11, 3'd0);
    push_fill(8'h22, 3'd0);
    do_req(1'b0, 16'h2200, 8'h00, 1'b0, 130, 1'b0);
    chk("wb_byte_in_mem", mem[16'h1101], 8'hAA);

    // Line 1 untouched by the miss; last byte of a line.
    do_req(1'b0, 16'h0021, 8'h00, 1'b1, 2, 1'b0);
    do_req(1'b0, 16'h221F, 8'h00, 1'b1, 2, 1'b0);
    chk("hit_cnt_4", hit_cnt, st(16'd4));
    chk("miss_cnt_3", miss_cnt, st(16'd3));

    // cs edge and stray ack during a fill are ignored.
    push_fill(8'h44, 3'd2);
    do_req(1'b0, 16'h4440, 8'h00, 1'b0, 66, 1'b1);
    chk("miss_cnt_4", miss_cnt, st(16'd4));

    // Dirty line 0, then reset part-way through its write-back.
    do_req(1'b1, 16'h2205, 8'h77, 1'b1, 2, 1'b0);
    push_wb(8'h22, 3'd0);
    push_fill(8'h33, 3'd0);
    @(negedge clk);
    cs = 1'b1; wr_rd = 1'b0; addr = 16'h3300;
    @(negedge clk);
    cs = 1'b0;
    n = 0;
    while (exp_q.size() > 58 && n < LIMIT) begin @(negedge clk); n++; end
    while (mem_req !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
    chk("pre_rst_req", mem_req, 1);
    chk("pre_rst_wr", mem_wr, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req", mem_req, 0);
    chk("async_rst_rdy", rdy, 1);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    last_rd = 8'h00;
    chk("rst2_cpu_dout", cpu_dout, 0);
    chk("rst2_hit_cnt", hit_cnt, 0);
    chk("rst2_miss_cnt", miss_cnt, 0);

    // Valid bits were cleared: miss with no write-back.
    push_fill(8'h22, 3'd0);
    do_req(1'b0, 16'h2200, 8'h00, 1'b0, 66, 1'b0);
    chk("rst2_miss_cnt_1", miss_cnt, st(16'd1));

    // Hit counter saturation.
`ifdef CACHE_STATS_EN
    @(negedge clk);
    force dut.r_hit_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_hit_cnt;
`endif
    do_req(1'b0, 16'h2200, 8'h00, 1'b1, 2, 1'b0);
    chk("hit_cnt_sat", hit_cnt, st(16'hFFFF));
    chk("miss_cnt_final", miss_cnt, st(16'd1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
